// File: rtl/alu_muldiv_sequencer.sv
// Iterative unsigned MUL/DIV sequencer that borrows the main ALU for its add/subtract steps.
// Optional MUL_EARLY_TERM_EN: MUL stops once the remaining multiplier bits are all zero.
module alu_muldiv_sequencer #(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sel,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result_lo,
  output logic [W-1:0]     result_hi,
  output logic             overflow,
  output logic             div_zero,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [W-1:0]     alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MOVE = 3'b010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // acc_q is the MUL accumulator or the DIV partial remainder; b_q is mcand or divisor;
  // sh_q is the multiplier (shifts right) or the dividend (shifts left).
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     res_lo_q, res_lo_d;
  logic [W-1:0]     res_hi_q, res_hi_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;

  logic [W:0]       div_t;
  logic             div_ge;

  assign div_t  = {acc_q, sh_q[W-1]};
  assign div_ge = div_t >= {1'b0, b_q};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      quot_q   <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      quot_q   <= quot_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    logic last;
    // NOTE: every variable gets a hold default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    b_d      = b_q;
    sh_d     = sh_q;
    quot_d   = quot_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    last     = 1'b0;

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (!is_div_q) begin
          if (sh_q[0]) begin
            acc_d = alu_result;
            if (alu_result < acc_q) ovf_d = 1'b1;
          end
          // A set top bit about to be shifted out still has multiplier bits left to weight it.
          if (b_q[W-1] && ((sh_q >> 1) != '0)) ovf_d = 1'b1;
          b_d  = b_q << 1;
          sh_d = sh_q >> 1;
        end else begin
          if (div_ge) begin
            acc_d  = alu_result;
            quot_d = {quot_q[W-2:0], 1'b1};
          end else begin
            acc_d  = div_t[W-1:0];
            quot_d = {quot_q[W-2:0], 1'b0};
          end
          sh_d = sh_q << 1;
        end

        last = (cnt_q == CNT_W'(W - 1));
`ifdef MUL_EARLY_TERM_EN
        if (!is_div_q && ((sh_q >> 1) == '0)) last = 1'b1;
`else
`endif
        if (last) begin
          state_d  = S_DONE;
          res_lo_d = is_div_q ? quot_d : acc_d;
          res_hi_d = is_div_q ? acc_d : '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          is_div_d = op_sel;
          cnt_d    = '0;
          acc_d    = '0;
          quot_d   = '0;
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
          b_d      = op_sel ? op_b : op_a;
          sh_d     = op_sel ? op_a : op_b;
          if (op_sel && (op_b == '0)) begin
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = op_a;
            dz_d     = 1'b1;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_MOVE;
    if (state_q == S_RUN) begin
      alu_b = b_q;
      if (is_div_q) begin
        alu_a    = div_t[W-1:0];
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a    = acc_q;
        alu_ctrl = ALU_ADD;
      end
    end
  end

  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;

endmodule
